laser_line_finder: RTL and testbench
====================================

// Module: laser_line_finder
// PURPOSE
//  Per-row laser-peak detector feeding zbt_controller. Watches the camera pixel stream
//  (hcount/vcount-aligned luma), finds the brightest column above threshold in each
//  active row, and presents it as quantised (x,y). x and y are held stable between
//  reports so the downstream ZBT writer can sample them at any hcount phase.
// PARAMETERS
//  H_ACTIVE  640    active pixels per row (hcount 0..H_ACTIVE-1)
//  V_ACTIVE  480    active rows per frame (vcount 0..V_ACTIVE-1)
//  THRESH    8'd128 minimum luma for a valid peak (strictly greater than)
//  X_SHIFT   2      column right-shift to form 8-bit x (640>>2 = 160 columns)
// PORTS
//  clk          in   1   pixel clock; all logic on rising edge
//  reset        in   1   synchronous, active-high
//  hcount       in   11  current pixel column, same cycle as pixel_luma
//  vcount       in   10  current row
//  pixel_luma   in   8   pixel brightness (red channel) for (hcount,vcount)
//  x            out  8   peak column >> X_SHIFT of last reported row
//  y            out  10  row index of last reported row
//  peak_luma    out  8   luma of reported peak
//  point_found  out  1   1 = last reported row had a pixel > THRESH
//  point_valid  out  1   one-cycle pulse when x/y/peak_luma/point_found update
//  frame_done   out  1   one-cycle pulse after the report for row V_ACTIVE-1
// BEHAVIOUR
//  Reset: x=0, y=0, peak_luma=0, point_found=0, point_valid=0, frame_done=0, state=IDLE,
//   internal max=0, max_col=0. Reset mid-row discards the partial row.
//  FSM: IDLE -> SCAN when hcount==0 and vcount<V_ACTIVE; SCAN -> REPORT when
//   hcount==H_ACTIVE-1 (that last pixel still evaluated); REPORT -> IDLE after 1 cycle.
//   Rows with vcount>=V_ACTIVE never leave IDLE.
//  SCAN: on entry (hcount==0 cycle) max<=pixel_luma, max_col<=0, row<=vcount.
//   Each later cycle: if pixel_luma > max then max<=pixel_luma, max_col<=hcount.
//   Ties keep the earliest (leftmost) column.
//  REPORT: found = (max > THRESH). If found: x<=max_col>>X_SHIFT (low 8 bits),
//   peak_luma<=max; else x<=0, peak_luma<=0. y<=row, point_found<=found,
//   point_valid<=1 for exactly this cycle. frame_done<=1 same cycle iff row==V_ACTIVE-1.
//  Latency: outputs update 2 clocks after the hcount==H_ACTIVE-1 pixel is presented.
//  x/y/peak_luma/point_found hold constant until the next REPORT.
//  If hcount jumps back to 0 while in SCAN (short line), the row is abandoned with no
//   report and SCAN restarts on the new row.
//  vcount is latched at row start; changes of vcount mid-row are ignored.
// TESTING
//  Row vcount=10, all luma 0 except hcount=300 luma 200 -> point_valid pulse, x=75,
//   y=10, peak_luma=200, point_found=1, 2 clk after hcount==639.
//  Row all luma 50 (<THRESH) -> point_valid pulse, point_found=0, x=0, peak_luma=0.
//  Row with luma 180 at hcount=100 and 180 at hcount=500 -> x=25 (leftmost tie wins).
//  Peak at hcount=0 and separately at hcount=639 -> x=0 and x=159 respectively.
//  Assert reset at hcount=320 of row 5 with peak at 100 -> no report for row 5; all
//   outputs 0; next full row reports normally.
//  Full frame sweep rows 0..524 -> exactly 480 point_valid pulses, one frame_done
//   coincident with y=479, none for vcount>=480.

Source files
------------

// File: rtl/laser_line_finder.sv
// Per-row laser-peak detector: tracks the brightest pixel of each active row and
// reports its quantised column, row index and luma once per row, holding them until the next report.
module laser_line_finder #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter logic [7:0]  THRESH   = 8'd128,
  parameter int          X_SHIFT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [7:0]  pixel_luma,
  output logic [7:0]  x,
  output logic [9:0]  y,
  output logic [7:0]  peak_luma,
  output logic        point_found,
  output logic        point_valid,
  output logic        frame_done
);

  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LIM  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t      state, next_state;
  logic        start_row, do_report, found;
  logic [7:0]  row_max;
  logic [10:0] row_max_col;
  logic [9:0]  row_idx;

  assign found = (row_max > THRESH);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A return of hcount to 0 while scanning means the previous line was short: drop it and restart.
  always_comb begin
    next_state = state;
    start_row  = 1'b0;
    do_report  = 1'b0;
    unique case (state)
      IDLE: begin
        if (hcount == 11'd0 && vcount < V_LIM) begin
          start_row  = 1'b1;
          next_state = SCAN;
        end
      end
      SCAN: begin
        if (hcount == 11'd0) begin
          if (vcount < V_LIM) start_row  = 1'b1;
          else                next_state = IDLE;
        end else if (hcount == H_LAST) begin
          next_state = REPORT;
        end
      end
      REPORT: begin
        do_report  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Strict greater-than keeps the leftmost column on ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_max     <= 8'd0;
      row_max_col <= 11'd0;
      row_idx     <= 10'd0;
      x           <= 8'd0;
      y           <= 10'd0;
      peak_luma   <= 8'd0;
      point_found <= 1'b0;
      point_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      point_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (start_row) begin
        row_max     <= pixel_luma;
        row_max_col <= 11'd0;
        row_idx     <= vcount;
      end else if (state == SCAN && pixel_luma > row_max) begin
        row_max     <= pixel_luma;
        row_max_col <= hcount;
      end
      if (do_report) begin
        x           <= found ? 8'(row_max_col >> X_SHIFT) : 8'd0;
        peak_luma   <= found ? row_max : 8'd0;
        y           <= row_idx;
        point_found <= found;
        point_valid <= 1'b1;
        frame_done  <= (row_idx == V_LAST);
      end
    end
  end

endmodule

// File: tb/tb_laser_line_finder.sv
// Directed bench for laser_line_finder: one task per scenario, each with its own
// hand-computed expectations; sweep rows use only hcount 0 and 639 to stay short.
module tb_laser_line_finder;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [7:0]  pixel_luma;
  logic [7:0]  x;
  logic [9:0]  y;
  logic [7:0]  peak_luma;
  logic        point_found;
  logic        point_valid;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  logic [7:0] row_luma [0:639];

  laser_line_finder dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .pixel_luma(pixel_luma),
    .x(x), .y(y), .peak_luma(peak_luma), .point_found(point_found),
    .point_valid(point_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs read right after reflect the last rising edge.
  task automatic pix(input logic [10:0] h, input logic [9:0] v, input logic [7:0] l);
    @(negedge clk);
    hcount = h;
    vcount = v;
    pixel_luma = l;
  endtask

  task automatic fill_row(input logic [7:0] val);
    for (int i = 0; i < 640; i++) row_luma[i] = val;
  endtask

  task automatic drive_row(input logic [9:0] v);
    for (int i = 0; i < 640; i++) pix(11'(i), v, row_luma[i]);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pix(11'd700, 10'd0, 8'd0);
    pix(11'd701, 10'd0, 8'd0);
    pix(11'd702, 10'd0, 8'd0);
    checks++;
    if ({x, y, peak_luma, point_found, point_valid, frame_done} !== 29'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs actual x=%0d y=%0d pl=%0d pf=%0b pv=%0b fd=%0b expected all 0",
               x, y, peak_luma, point_found, point_valid, frame_done);
    end
    reset = 1'b0;
    pix(11'd703, 10'd0, 8'd0);
  endtask

  task automatic test_single_peak;
    fill_row(8'd0);
    row_luma[300] = 8'd200;
    drive_row(10'd10);
    pix(11'd640, 10'd10, 8'd0);
    checks++;
    if (point_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL peak_early_pv actual=%0b expected=0", point_valid);
    end
    pix(11'd641, 10'd10, 8'd0);
    checks++;
    if (point_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL peak_pv actual=%0b expected=1", point_valid);
    end
    checks++;
    if (x !== 8'd75 || y !== 10'd10 || peak_luma !== 8'd200 || point_found !== 1'b1) begin
      errors++;
      $display("[TB] FAIL peak_report actual x=%0d y=%0d pl=%0d pf=%0b expected x=75 y=10 pl=200 pf=1",
               x, y, peak_luma, point_found);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("[TB] FAIL peak_fd actual=%0b expected=0", frame_done);
    end
    pix(11'd642, 10'd10, 8'd0);
    checks++;
    if (point_valid !== 1'b0 || x !== 8'd75) begin
      errors++; $display("[TB] FAIL peak_pulse_hold actual pv=%0b x=%0d expected pv=0 x=75", point_valid, x);
    end
  endtask

  task automatic test_below_threshold;
    logic [7:0] levels [0:1];
    levels[0] = 8'd50;
    levels[1] = 8'd128;
    for (int k = 0; k < 2; k++) begin
      fill_row(levels[k]);
      drive_row(10'(11 + k));
      pix(11'd640, 10'd0, 8'd0);
      pix(11'd641, 10'd0, 8'd0);
      checks++;
      if (point_valid !== 1'b1 || point_found !== 1'b0 || x !== 8'd0 || peak_luma !== 8'd0 ||
          y !== 10'(11 + k)) begin
        errors++;
        $display("[TB] FAIL below_thresh_%0d actual pv=%0b pf=%0b x=%0d pl=%0d y=%0d expected pv=1 pf=0 x=0 pl=0 y=%0d",
                 levels[k], point_valid, point_found, x, peak_luma, y, 11 + k);
      end
      pix(11'd642, 10'd0, 8'd0);
    end
  endtask

  task automatic test_tie;
    fill_row(8'd0);
    row_luma[100] = 8'd180;
    row_luma[500] = 8'd180;
    drive_row(10'd12);
    pix(11'd640, 10'd0, 8'd0);
    pix(11'd641, 10'd0, 8'd0);
    checks++;
    if (point_valid !== 1'b1 || x !== 8'd25 || peak_luma !== 8'd180) begin
      errors++;
      $display("[TB] FAIL tie_leftmost actual pv=%0b x=%0d pl=%0d expected pv=1 x=25 pl=180", point_valid, x, peak_luma);
    end
    pix(11'd642, 10'd0, 8'd0);
  endtask

  task automatic test_edges;
    fill_row(8'd0);
    row_luma[0] = 8'd255;
    drive_row(10'd20);
    pix(11'd640, 10'd0, 8'd0);
    pix(11'd641, 10'd0, 8'd0);
    checks++;
    if (point_valid !== 1'b1 || x !== 8'd0 || peak_luma !== 8'd255 || point_found !== 1'b1) begin
      errors++;
      $display("[TB] FAIL edge_col0 actual pv=%0b x=%0d pl=%0d pf=%0b expected pv=1 x=0 pl=255 pf=1",
               point_valid, x, peak_luma, point_found);
    end
    pix(11'd642, 10'd0, 8'd0);
    fill_row(8'd0);
    row_luma[639] = 8'd129;
    drive_row(10'd21);
    pix(11'd640, 10'd0, 8'd0);
    pix(11'd641, 10'd0, 8'd0);
    checks++;
    if (point_valid !== 1'b1 || x !== 8'd159 || peak_luma !== 8'd129 || point_found !== 1'b1 || y !== 10'd21) begin
      errors++;
      $display("[TB] FAIL edge_col639 actual pv=%0b x=%0d pl=%0d pf=%0b y=%0d expected pv=1 x=159 pl=129 pf=1 y=21",
               point_valid, x, peak_luma, point_found, y);
    end
    pix(11'd642, 10'd0, 8'd0);
  endtask

  task automatic test_reset_mid_row;
    int pv_seen = 0;
    fill_row(8'd0);
    row_luma[100] = 8'd220;
    for (int i = 0; i < 320; i++) pix(11'(i), 10'd5, row_luma[i]);
    pix(11'd320, 10'd5, row_luma[320]);
    reset = 1'b1;
    for (int i = 321; i < 645; i++) begin
      pix(11'(i), 10'd5, (i < 640) ? row_luma[i] : 8'd0);
      reset = 1'b0;
      if (point_valid === 1'b1) pv_seen++;
    end
    checks++;
    if (pv_seen !== 0) begin
      errors++; $display("[TB] FAIL reset_row_no_report actual pulses=%0d expected=0", pv_seen);
    end
    checks++;
    if ({x, y, peak_luma, point_found, frame_done} !== 28'd0) begin
      errors++;
      $display("[TB] FAIL reset_row_outputs actual x=%0d y=%0d pl=%0d pf=%0b fd=%0b expected all 0",
               x, y, peak_luma, point_found, frame_done);
    end
    drive_row(10'd6);
    pix(11'd640, 10'd6, 8'd0);
    pix(11'd641, 10'd6, 8'd0);
    checks++;
    if (point_valid !== 1'b1 || x !== 8'd25 || y !== 10'd6 || peak_luma !== 8'd220 || point_found !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_next_row actual pv=%0b x=%0d y=%0d pl=%0d pf=%0b expected pv=1 x=25 y=6 pl=220 pf=1",
               point_valid, x, y, peak_luma, point_found);
    end
    pix(11'd642, 10'd6, 8'd0);
  endtask

  // Short line abandoned, then a full row whose vcount changes halfway through.
  task automatic test_short_line;
    int pv_seen = 0;
    for (int i = 0; i < 200; i++) begin
      pix(11'(i), 10'd7, (i == 50) ? 8'd250 : 8'd0);
      if (point_valid === 1'b1) pv_seen++;
    end
    for (int i = 0; i < 640; i++) begin
      pix(11'(i), (i < 300) ? 10'd8 : 10'd9, (i == 400) ? 8'd190 : 8'd0);
      if (point_valid === 1'b1) pv_seen++;
    end
    checks++;
    if (pv_seen !== 0) begin
      errors++; $display("[TB] FAIL short_line_no_report actual pulses=%0d expected=0", pv_seen);
    end
    pix(11'd640, 10'd9, 8'd0);
    pix(11'd641, 10'd9, 8'd0);
    checks++;
    if (point_valid !== 1'b1 || x !== 8'd100 || y !== 10'd8 || peak_luma !== 8'd190) begin
      errors++;
      $display("[TB] FAIL short_line_restart actual pv=%0b x=%0d y=%0d pl=%0d expected pv=1 x=100 y=8 pl=190",
               point_valid, x, y, peak_luma);
    end
    pix(11'd642, 10'd9, 8'd0);
  endtask

  task automatic test_frame_sweep;
    int pv_count = 0;
    int fd_count = 0;
    int fd_bad = 0;
    logic [10:0] hs [0:3];
    hs[0] = 11'd0; hs[1] = 11'd639; hs[2] = 11'd640; hs[3] = 11'd641;
    for (int r = 0; r < 525; r++) begin
      for (int p = 0; p < 4; p++) begin
        pix(hs[p], 10'(r), (p == 1) ? 8'd200 : 8'd0);
        if (point_valid === 1'b1) pv_count++;
        if (frame_done === 1'b1) begin
          fd_count++;
          if (y !== 10'd479 || point_valid !== 1'b1) fd_bad++;
        end
      end
    end
    checks++;
    if (pv_count !== 480) begin
      errors++; $display("[TB] FAIL sweep_pv_count actual=%0d expected=480", pv_count);
    end
    checks++;
    if (fd_count !== 1 || fd_bad !== 0) begin
      errors++; $display("[TB] FAIL sweep_frame_done actual count=%0d misaligned=%0d expected count=1 misaligned=0",
                         fd_count, fd_bad);
    end
    checks++;
    if (y !== 10'd479 || x !== 8'd159) begin
      errors++; $display("[TB] FAIL sweep_last_report actual y=%0d x=%0d expected y=479 x=159", y, x);
    end
  endtask

  initial begin
    reset = 1'b1;
    hcount = 11'd700;
    vcount = 10'd0;
    pixel_luma = 8'd0;
    test_reset;
    test_single_peak;
    test_below_threshold;
    test_tie;
    test_edges;
    test_reset_mid_row;
    test_short_line;
    test_frame_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
